// File: rtl/rcc_reg2ahb_pkg.sv
// Shared constants and FSM state type for the register-request to AHB-lite master bridge.
package rcc_reg2ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_ERR     = 2'b01;
  localparam logic [1:0] RSP_ILLSTRB = 2'b10;
  localparam logic [1:0] RSP_TMO     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/rcc_reg2ahb_strb_dec.sv
// Write-strobe decoder: maps a 4-bit byte strobe onto AHB size and address LSBs.
module rcc_reg2ahb_strb_dec
  import rcc_reg2ahb_pkg::*;
(
  input  logic [3:0] strb,
  output logic       legal,
  output logic [2:0] hsize,
  output logic [1:0] addr_lsb
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    legal    = 1'b1;
    hsize    = HSIZE_WORD;
    addr_lsb = 2'b00;
    unique case (strb)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; addr_lsb = 2'b10; end
      4'b0001: hsize = HSIZE_BYTE;
      4'b0010: begin hsize = HSIZE_BYTE; addr_lsb = 2'b01; end
      4'b0100: begin hsize = HSIZE_BYTE; addr_lsb = 2'b10; end
      4'b1000: begin hsize = HSIZE_BYTE; addr_lsb = 2'b11; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rcc_reg2ahb_master.sv
// Single-transfer AHB-lite master driven by a simple register-request interface.
// Optional wait-state timeout is compiled in with `define RCC_REG2AHB_TIMEOUT_EN.
module rcc_reg2ahb_master
  import rcc_reg2ahb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WW          = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          mreq,
  input  logic          mwrite,
  input  logic [AW-1:0] maddr,
  input  logic [WW-1:0] mwstrb,
  input  logic [DW-1:0] mdata,
  output logic          busy,
  output logic          sdone,
  output logic [1:0]    sresp,
  output logic [DW-1:0] sdata,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [DW-1:0] hwdata,
  input  logic          hready,
  input  logic          hresp,
  input  logic [DW-1:0] hrdata
`ifdef RCC_REG2AHB_TIMEOUT_EN
  ,
  output logic          timeout
`endif
);

  state_t        state, state_n;
  logic [AW-1:0] haddr_n;
  logic [1:0]    htrans_n, sresp_n;
  logic          hwrite_n, busy_n, sdone_n;
  logic [2:0]    hsize_n;
  logic [DW-1:0] hwdata_n, wdata, wdata_n, sdata_n;
  logic          dec_legal;
  logic [2:0]    dec_hsize;
  logic [1:0]    dec_lsb;
  logic          tmo_xfer;

  rcc_reg2ahb_strb_dec u_strb_dec (
    .strb     (mwstrb),
    .legal    (dec_legal),
    .hsize    (dec_hsize),
    .addr_lsb (dec_lsb)
  );

  always_comb begin
    state_n  = state;
    haddr_n  = haddr;
    htrans_n = htrans;
    hwrite_n = hwrite;
    hsize_n  = hsize;
    hwdata_n = hwdata;
    wdata_n  = wdata;
    busy_n   = busy;
    sdone_n  = 1'b0;
    sresp_n  = sresp;
    sdata_n  = sdata;
    unique case (state)
      // DONE behaves like IDLE for request sampling so back-to-back requests lose no cycle.
      ST_IDLE, ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        if (mreq) begin
          if (mwrite && !dec_legal) begin
            state_n = ST_DONE;
            sdone_n = 1'b1;
            sresp_n = RSP_ILLSTRB;
          end else begin
            state_n  = ST_ADDR;
            htrans_n = HTRANS_NONSEQ;
            busy_n   = 1'b1;
            hwrite_n = mwrite;
            wdata_n  = mdata;
            if (!mwrite) begin
              haddr_n = {maddr[AW-1:2], 2'b00};
              hsize_n = HSIZE_WORD;
            end else if (dec_hsize == HSIZE_WORD) begin
              haddr_n = maddr;
              hsize_n = HSIZE_WORD;
            end else begin
              haddr_n = {maddr[AW-1:2], dec_lsb};
              hsize_n = dec_hsize;
            end
          end
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_n  = ST_DATA;
          htrans_n = HTRANS_IDLE;
          hwdata_n = wdata;
        end
      end
      ST_DATA: begin
        if (hready) begin
          state_n = ST_DONE;
          sdone_n = 1'b1;
          busy_n  = 1'b0;
          if (hresp) begin
            sresp_n = RSP_ERR;
          end else begin
            sresp_n = RSP_OKAY;
            if (!hwrite) sdata_n = hrdata;
          end
          if (tmo_xfer) sresp_n = RSP_TMO;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= ST_IDLE;
      haddr  <= '0;
      htrans <= HTRANS_IDLE;
      hwrite <= 1'b0;
      hsize  <= HSIZE_WORD;
      hwdata <= '0;
      wdata  <= '0;
      busy   <= 1'b0;
      sdone  <= 1'b0;
      sresp  <= RSP_OKAY;
      sdata  <= '0;
    end else begin
      state  <= state_n;
      haddr  <= haddr_n;
      htrans <= htrans_n;
      hwrite <= hwrite_n;
      hsize  <= hsize_n;
      hwdata <= hwdata_n;
      wdata  <= wdata_n;
      busy   <= busy_n;
      sdone  <= sdone_n;
      sresp  <= sresp_n;
      sdata  <= sdata_n;
    end
  end

`ifdef RCC_REG2AHB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;
  logic          counting;

  assign counting = (state == ST_ADDR || state == ST_DATA) && !hready &&
                    (wait_cnt != CW'(TIMEOUT_CYC));
  assign tmo_xfer = (wait_cnt == CW'(TIMEOUT_CYC));

  // Counter saturates at the limit; the per-transfer flag is simply "counter saturated".
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state_n == ST_ADDR && state != ST_ADDR) begin
        wait_cnt <= '0;
      end else if (counting) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (wait_cnt == CW'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign tmo_xfer       = 1'b0;
`endif

endmodule

// File: tb/tb_rcc_reg2ahb_master.sv
// Directed self-checking bench for rcc_reg2ahb_master (timeout case runs when
// RCC_REG2AHB_TIMEOUT_EN is defined).
module tb_rcc_reg2ahb_master;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        mreq, mwrite;
  logic [31:0] maddr, mdata, hrdata;
  logic [3:0]  mwstrb;
  logic        busy, sdone, hwrite, hready, hresp;
  logic [1:0]  sresp, htrans;
  logic [31:0] sdata, haddr, hwdata;
  logic [2:0]  hsize;
`ifdef RCC_REG2AHB_TIMEOUT_EN
  logic        timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  rcc_reg2ahb_master #(.AW(32), .DW(32), .WW(4), .TIMEOUT_CYC(4)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .mreq    (mreq),
    .mwrite  (mwrite),
    .maddr   (maddr),
    .mwstrb  (mwstrb),
    .mdata   (mdata),
    .busy    (busy),
    .sdone   (sdone),
    .sresp   (sresp),
    .sdata   (sdata),
    .haddr   (haddr),
    .htrans  (htrans),
    .hwrite  (hwrite),
    .hsize   (hsize),
    .hwdata  (hwdata),
    .hready  (hready),
    .hresp   (hresp),
    .hrdata  (hrdata)
`ifdef RCC_REG2AHB_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the middle (falling edge) of the next cycle: sample and drive point.
  task automatic step();
    @(negedge hclk);
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    mreq = 1'b1; mwrite = wr; maddr = a; mwstrb = s; mdata = d;
  endtask

  task automatic no_req();
    mreq = 1'b0; mwrite = 1'b0; maddr = '0; mwstrb = '0; mdata = '0;
  endtask

  initial begin
    hresetn = 1'b0; no_req(); hready = 1'b1; hresp = 1'b0; hrdata = '0;
    step();
    check("rst_htrans", htrans, 2'b00);
    check("rst_haddr",  haddr,  32'h0);
    check("rst_hsize",  hsize,  3'b010);
    check("rst_hwrite", hwrite, 1'b0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_busy",   busy,   1'b0);
    check("rst_sdone",  sdone,  1'b0);
    check("rst_sresp",  sresp,  2'b00);
    check("rst_sdata",  sdata,  32'h0);
`ifdef RCC_REG2AHB_TIMEOUT_EN
    check("rst_timeout", timeout, 1'b0);
`endif
    hresetn = 1'b1;
    step();

    // Word write, minimum latency, then a back-to-back read issued in the sdone cycle.
    req(1'b1, 32'h58, 4'b1111, 32'hA5A5_0001);
    step(); no_req();
    check("ww_c1_htrans", htrans, 2'b10);
    check("ww_c1_haddr",  haddr,  32'h58);
    check("ww_c1_hsize",  hsize,  3'b010);
    check("ww_c1_hwrite", hwrite, 1'b1);
    check("ww_c1_busy",   busy,   1'b1);
    step();
    check("ww_c2_htrans", htrans, 2'b00);
    check("ww_c2_hwdata", hwdata, 32'hA5A5_0001);
    check("ww_c2_sdone",  sdone,  1'b0);
    step();
    check("ww_c3_sdone", sdone, 1'b1);
    check("ww_c3_sresp", sresp, 2'b00);
    check("ww_c3_busy",  busy,  1'b0);
    req(1'b0, 32'h13, 4'b0000, 32'h0);
    step(); no_req();
    check("b2b_sdone",  sdone,  1'b0);
    check("b2b_htrans", htrans, 2'b10);
    check("b2b_haddr",  haddr,  32'h10);
    check("b2b_hwrite", hwrite, 1'b0);
    check("b2b_busy",   busy,   1'b1);

    // Read with two data-phase wait states.
    step(); hready = 1'b0;
    step();
    check("rd_wait_busy", busy, 1'b1);
    step(); hready = 1'b1; hrdata = 32'h1234_5678;
    check("rd_wait_sdone", sdone, 1'b0);
    step(); hrdata = 32'hFFFF_FFFF;
    check("rd_sdone", sdone, 1'b1);
    check("rd_sresp", sresp, 2'b00);
    check("rd_sdata", sdata, 32'h1234_5678);
    step();
    check("rd_sdone_pulse", sdone, 1'b0);
    check("rd_sdata_hold",  sdata, 32'h1234_5678);

    // Byte write at lane 2.
    req(1'b1, 32'h20, 4'b0100, 32'h00CC_0000);
    step(); no_req();
    check("bw_haddr",  haddr,  32'h22);
    check("bw_hsize",  hsize,  3'b000);
    check("bw_htrans", htrans, 2'b10);
    step();
    check("bw_hwdata", hwdata, 32'h00CC_0000);
    step();
    check("bw_sdone", sdone, 1'b1);
    check("bw_sdata_hold", sdata, 32'h1234_5678);
    step();

    // Upper halfword write with unaligned address LSBs.
    req(1'b1, 32'h41, 4'b1100, 32'hBEEF_0000);
    step(); no_req();
    check("hw_haddr", haddr, 32'h42);
    check("hw_hsize", hsize, 3'b001);
    step(); step();
    check("hw_sdone", sdone, 1'b1);
    step();

    // Illegal strobes: no bus activity, completion one cycle later.
    req(1'b1, 32'h60, 4'b0110, 32'h1);
    step(); no_req();
    check("ill_sdone",  sdone,  1'b1);
    check("ill_sresp",  sresp,  2'b10);
    check("ill_htrans", htrans, 2'b00);
    check("ill_busy",   busy,   1'b0);
    step();
    req(1'b1, 32'h64, 4'b0000, 32'h2);
    step(); no_req();
    check("ill0_sresp",  sresp,  2'b10);
    check("ill0_htrans", htrans, 2'b00);
    step();

    // Two-cycle ERROR response; requests during busy are ignored.
    req(1'b0, 32'h30, 4'b0000, 32'h0);
    hrdata = 32'hDEAD_BEEF;
    step(); req(1'b0, 32'h70, 4'b0000, 32'h0);
    check("err_c1_htrans", htrans, 2'b10);
    hresp = 1'b1; hready = 1'b1;
    step(); hready = 1'b0;
    check("err_c2_htrans", htrans, 2'b00);
    step(); hready = 1'b1; no_req();
    check("err_c3_htrans", htrans, 2'b00);
    check("err_c3_haddr",  haddr,  32'h30);
    step(); hresp = 1'b0;
    check("err_sdone", sdone, 1'b1);
    check("err_sresp", sresp, 2'b01);
    check("err_sdata", sdata, 32'h1234_5678);
    step();
    check("err_no_requeue", htrans, 2'b00);

    // Reset asserted during the data phase.
    req(1'b1, 32'h80, 4'b1111, 32'h5555_AAAA);
    step(); no_req();
    step(); hready = 1'b0;
    check("rstm_in_data_busy", busy, 1'b1);
    #1 hresetn = 1'b0;
    #1;
    check("rstm_htrans", htrans, 2'b00);
    check("rstm_busy",   busy,   1'b0);
    check("rstm_haddr",  haddr,  32'h0);
    step(); hresetn = 1'b1; hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstm_no_sdone", sdone, 1'b0);
    end

`ifdef RCC_REG2AHB_TIMEOUT_EN
    // Six wait states against a limit of four.
    req(1'b0, 32'h90, 4'b0000, 32'h0);
    step(); no_req();
    step(); hready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("tmo_flag",  timeout, 1'b1);
    check("tmo_sdone_early", sdone, 1'b0);
    hready = 1'b1;
    step();
    check("tmo_sdone", sdone, 1'b1);
    check("tmo_sresp", sresp, 2'b11);
    step();
    check("tmo_sticky", timeout, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
